synaptic_update_engine: RTL

SYNAPTIC_UPDATE_ENGINE -- requirements
Module: synaptic_update_engine

---
 rtl/snn_pkg.sv | 23 ++
 rtl/sat_adder.sv | 31 +++
 rtl/synaptic_update_engine.sv | 135 +++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network update datapath: default widths
// and the one-hot state encoding of the synaptic update engine.
package snn_pkg;

  localparam int NUM_NEURONS_DEF = 4;
  localparam int DATA_W_DEF      = 17;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_DEQ   = 5'b00010,
    S_READ  = 5'b00100,
    S_LATCH = 5'b01000,
    S_WRITE = 5'b10000
  } state_e;

  // Tag width for a neuron count; never narrower than one bit.
  function automatic int tag_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int TAG_W_DEF = tag_w(NUM_NEURONS_DEF);

endpackage

// File: rtl/sat_adder.sv
// Signed saturating adder: adds at DATA_W+1 bits and clamps to the DATA_W
// two's-complement range, flagging when a clamp occurred.
module sat_adder
  import snn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              sat
);

  logic [DATA_W:0] wide_s;

  assign wide_s = {a[DATA_W-1], a} + {b[DATA_W-1], b};

  // Overflow shows as disagreement between the two top bits of the wide sum.
  always_comb begin
    sum = wide_s[DATA_W-1:0];
    sat = 1'b0;
    if (wide_s[DATA_W] != wide_s[DATA_W-1]) begin
      sum = {wide_s[DATA_W], {(DATA_W-1){~wide_s[DATA_W]}}};
      sat = 1'b1;
    end else begin
      sum = wide_s[DATA_W-1:0];
      sat = 1'b0;
    end
  end

endmodule

// File: rtl/synaptic_update_engine.sv
// Walks one fired source neuron's weight row, adding each weight into i_next[dst].
// Build option ZERO_SKIP_EN: zero weights skip the write-back entirely.
module synaptic_update_engine
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TAG_W       = tag_w(NUM_NEURONS)
) (
  input  logic              clk,
  input  logic              asyn_reset,
  input  logic              fifo_empty,
  input  logic [TAG_W-1:0]  src_tag_in,
  output logic              req_deq,
  output logic              rd_en,
  output logic [TAG_W-1:0]  rd_src_tag,
  output logic [TAG_W-1:0]  rd_dst_tag,
  input  logic [DATA_W-1:0] weight_in,
  input  logic [DATA_W-1:0] i_next_in,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [TAG_W-1:0]  wr_tag,
  output logic [DATA_W-1:0] i_next_out,
  output logic              sat_flag,
  output logic              busy,
  output logic [4:0]        state
);

  localparam logic [TAG_W-1:0] LAST_DST = TAG_W'(NUM_NEURONS - 1);

  state_e            state_q, state_d;
  logic [TAG_W-1:0]  src_q, src_d;
  logic [TAG_W-1:0]  dst_q, dst_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              sat_q, sat_d;
  logic [DATA_W-1:0] add_sum;
  logic              add_sat;
  logic              last_dst;

  sat_adder #(.DATA_W(DATA_W)) u_sat_adder (
    .a   (i_next_in),
    .b   (weight_in),
    .sum (add_sum),
    .sat (add_sat)
  );

  assign last_dst = (dst_q == LAST_DST);

  // Next-state and datapath update; sat_q only survives while a write is pending.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    result_d = result_q;
    sat_d    = sat_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) state_d = S_DEQ;
        else             state_d = S_IDLE;
      end
      S_DEQ: begin
        src_d   = src_tag_in;
        dst_d   = {TAG_W{1'b0}};
        state_d = S_READ;
      end
      S_READ: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        result_d = add_sum;
        sat_d    = add_sat;
        state_d  = S_WRITE;
`ifdef ZERO_SKIP_EN
        if (weight_in == {DATA_W{1'b0}}) begin
          sat_d = 1'b0;
          if (last_dst) begin
            state_d = S_IDLE;
          end else begin
            dst_d   = dst_q + TAG_W'(1);
            state_d = S_READ;
          end
        end else begin
          state_d = S_WRITE;
        end
`endif
      end
      S_WRITE: begin
        if (wr_ready) begin
          sat_d = 1'b0;
          if (last_dst) begin
            state_d = S_IDLE;
          end else begin
            dst_d   = dst_q + TAG_W'(1);
            state_d = S_READ;
          end
        end else begin
          state_d = S_WRITE;
        end
      end
      default: begin
        state_d = S_IDLE;
        sat_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state_q  <= S_IDLE;
      src_q    <= {TAG_W{1'b0}};
      dst_q    <= {TAG_W{1'b0}};
      result_q <= {DATA_W{1'b0}};
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      result_q <= result_d;
      sat_q    <= sat_d;
    end
  end

  assign state      = state_q;
  assign busy       = (state_q != S_IDLE);
  assign req_deq    = (state_q == S_DEQ);
  assign rd_en      = (state_q == S_READ);
  assign wr_en      = (state_q == S_WRITE);
  assign rd_src_tag = src_q;
  assign rd_dst_tag = dst_q;
  assign wr_tag     = dst_q;
  assign i_next_out = result_q;
  assign sat_flag   = sat_q;

endmodule
